// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back size encodings, architectural register
// numbers and the link return-address offset.
package cpu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } wr_size_e;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;
  localparam int LINK_OFS = 4;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file bus: ID-stage read ports and scoreboard set, WB-stage
// main and link write ports.
interface regfile_mp_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;

  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic [1:0]           wr_size;
  logic                 wr_sext;

  logic                 link_en;
  logic [DW-1:0]        link_pc;

  logic                 sb_set;
  logic [AW-1:0]        sb_addr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_size, wr_sext,
           link_en, link_pc, sb_set, sb_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_size, wr_sext,
           link_en, link_pc, sb_set, sb_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/wb_extend.sv
// Byte/half/word sign or zero extension of write-back data; shared with the
// load unit.
module wb_extend
  import cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data,
  input  logic [1:0]    size,
  input  logic          sext,
  output logic [DW-1:0] ext
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ext = data;
    case (size)
      SZ_BYTE: ext = {{(DW-8){sext & data[7]}}, data[7:0]};
      SZ_HALF: ext = {{(DW-16){sext & data[15]}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-through bypass,
// link write port and per-register busy scoreboard.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = REG_RA,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  localparam int            DEPTH  = 2**AW;
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [DEPTH-1:0][DW-1:0] regs;
  logic [DEPTH-1:0]         busy, busy_nxt;
  logic [DW-1:0]            wr_ext, link_val;
  logic                     main_we, link_we;

  wb_extend #(.DW(DW)) u_ext (
    .data (bus.wr_data),
    .size (bus.wr_size),
    .sext (bus.wr_sext),
    .ext  (wr_ext)
  );

  assign link_val = bus.link_pc + DW'(LINK_OFS);

  // Writes to register 0 are dropped here, so regs[0] never leaves zero.
  // The main port takes the link register when both target it.
  assign main_we = bus.wr_en && (bus.wr_addr != ZERO_A);
  assign link_we = bus.link_en && (LINK_A != ZERO_A) &&
                   !(bus.wr_en && (bus.wr_addr == LINK_A));

  // NOTE: the file is built from flops, not a RAM macro, so an async clear of
  // the whole array is legal here; a true SRAM array cannot be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (link_we) regs[LINK_A]      <= link_val;
      if (main_we) regs[bus.wr_addr] <= wr_ext;
    end
  end

  // Clear on committed write first, then a new outstanding load overrides.
  always_comb begin
    busy_nxt = busy;
    if (main_we) busy_nxt[bus.wr_addr] = 1'b0;
    if (link_we) busy_nxt[LINK_A]      = 1'b0;
    if (bus.sb_set && (bus.sb_addr != ZERO_A)) busy_nxt[bus.sb_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit_main, hit_link;

    assign ra       = bus.rd_addr[k*AW +: AW];
    assign hit_main = (BYPASS != 0) && main_we && (bus.wr_addr == ra);
    assign hit_link = (BYPASS != 0) && link_we && (LINK_A == ra);

    // Outputs are forced quiet while reset is held, even if a write is driven.
    assign bus.rd_data[k*DW +: DW] = !rst_n   ? '0       :
                                     hit_main ? wr_ext   :
                                     hit_link ? link_val : regs[ra];
    assign bus.rd_busy[k] = rst_n && busy[ra] && !(hit_main || hit_link);
  end

endmodule
